// File: rtl/fetch_decode_reg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_decode_reg
//  Purpose  : IF/ID pipeline register with stall hold, multi-cycle flush
//             squash and optional performance counters (FD_PERF_CNT_EN).
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_decode_reg #(
    parameter int          FlushCycles = 1,
    parameter logic [5:0]  NopFunct    = 6'h15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [5:0]  OpCode,
    input  logic [5:0]  Function,
    input  logic [31:0] PCPlusFour,
    input  logic [4:0]  Rs1,
    input  logic [4:0]  Rs2,
    input  logic [4:0]  Rd,
    input  logic        RdIsFp,
    input  logic [15:0] Immediate,
    output logic [5:0]  DOpCode,
    output logic [5:0]  DFunction,
    output logic [31:0] DPCPlusFour,
    output logic [4:0]  DRs1,
    output logic [4:0]  DRs2,
    output logic [5:0]  DRd,
    output logic [15:0] DImmediate,
    output logic        DValid,
    output logic [31:0] StallCount,
    output logic [31:0] FlushCount
);

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_t;

    localparam int         c_SQ_INIT_INT = (FlushCycles > 1) ? (FlushCycles - 2) : 0;
    localparam logic [1:0] c_SQ_INIT     = 2'(c_SQ_INIT_INT);

    state_t      state_q;
    logic [1:0]  sq_cnt_q;
    logic [5:0]  op_q;
    logic [5:0]  fn_q;
    logic [31:0] pc_q;
    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;
    logic [5:0]  rd_q;
    logic [15:0] imm_q;
    logic        valid_q;

    logic w_load;
    logic w_bubble;
    logic w_is_nop;

    // Flush outranks stall; a squash slot is consumed only on an unstalled edge.
    assign w_load   = flush | ~stall;
    assign w_bubble = flush | (~stall & (state_q == SQUASH));
    assign w_is_nop = (OpCode == 6'h00) && (Function == NopFunct);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            sq_cnt_q <= 2'd0;
            op_q     <= 6'h00;
            fn_q     <= NopFunct;
            pc_q     <= 32'h0;
            rs1_q    <= 5'd0;
            rs2_q    <= 5'd0;
            rd_q     <= 6'd0;
            imm_q    <= 16'h0;
            valid_q  <= 1'b0;
        end else begin
            if (w_load) begin
                pc_q <= PCPlusFour;
                if (w_bubble) begin
                    op_q    <= 6'h00;
                    fn_q    <= NopFunct;
                    rs1_q   <= 5'd0;
                    rs2_q   <= 5'd0;
                    rd_q    <= 6'd0;
                    imm_q   <= 16'h0;
                    valid_q <= 1'b0;
                end else begin
                    op_q    <= OpCode;
                    fn_q    <= Function;
                    rs1_q   <= Rs1;
                    rs2_q   <= Rs2;
                    rd_q    <= {RdIsFp, Rd};
                    imm_q   <= Immediate;
                    valid_q <= ~w_is_nop;
                end
            end

            if (flush) begin
                state_q  <= (FlushCycles > 1) ? SQUASH : RUN;
                sq_cnt_q <= c_SQ_INIT;
            end else if (~stall && (state_q == SQUASH)) begin
                if (sq_cnt_q == 2'd0) begin
                    state_q <= RUN;
                end else begin
                    sq_cnt_q <= sq_cnt_q - 2'd1;
                end
            end
        end
    end

    assign DOpCode     = op_q;
    assign DFunction   = fn_q;
    assign DPCPlusFour = pc_q;
    assign DRs1        = rs1_q;
    assign DRs2        = rs2_q;
    assign DRd         = rd_q;
    assign DImmediate  = imm_q;
    assign DValid      = valid_q;

`ifdef FD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'h0;
            flush_cnt_q <= 32'h0;
        end else begin
            if (stall && !flush) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;
`else
    assign StallCount = 32'h0;
    assign FlushCount = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_decode_reg
//  Purpose  : Self-checking bench for fetch_decode_reg (FlushCycles 2 and 3).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_decode_reg;

    localparam logic [5:0] c_NOPF = 6'h15;

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [5:0]  rd;
        logic [15:0] imm;
        logic        v;
    } outs_t;

    typedef struct packed {
        logic        rst;
        logic        stl;
        logic        fl;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        fp;
        logic [15:0] imm;
        logic [31:0] pc;
    } ins_t;

    typedef struct packed {
        ins_t        in;
        logic [5:0]  e_op;
        logic [5:0]  e_rd;
        logic [31:0] e_pc;
        logic        e_v;
    } vec_t;

    logic        clk;
    logic        reset, stall, flush, RdIsFp;
    logic [5:0]  OpCode, Function;
    logic [31:0] PCPlusFour;
    logic [4:0]  Rs1, Rs2, Rd;
    logic [15:0] Immediate;

    outs_t       g0, g1;
    logic [31:0] sc0, fc0, sc1, fc1;

    ins_t        cur;
    outs_t       m_out [2];
    int          m_left[2];
    logic [31:0] m_sc  [2];
    logic [31:0] m_fc  [2];
    int          fc_of [2];

    int n_chk  = 0;
    int n_fail = 0;

    fetch_decode_reg #(.FlushCycles(2), .NopFunct(c_NOPF)) dut2 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .OpCode(OpCode), .Function(Function), .PCPlusFour(PCPlusFour),
        .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd), .RdIsFp(RdIsFp), .Immediate(Immediate),
        .DOpCode(g0.op), .DFunction(g0.fn), .DPCPlusFour(g0.pc),
        .DRs1(g0.rs1), .DRs2(g0.rs2), .DRd(g0.rd), .DImmediate(g0.imm),
        .DValid(g0.v), .StallCount(sc0), .FlushCount(fc0)
    );

    fetch_decode_reg #(.FlushCycles(3), .NopFunct(c_NOPF)) dut3 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .OpCode(OpCode), .Function(Function), .PCPlusFour(PCPlusFour),
        .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd), .RdIsFp(RdIsFp), .Immediate(Immediate),
        .DOpCode(g1.op), .DFunction(g1.fn), .DPCPlusFour(g1.pc),
        .DRs1(g1.rs1), .DRs2(g1.rs2), .DRd(g1.rd), .DImmediate(g1.imm),
        .DValid(g1.v), .StallCount(sc1), .FlushCount(fc1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic outs_t bubble(input logic [31:0] pc);
        outs_t o;
        o    = '0;
        o.fn = c_NOPF;
        o.pc = pc;
        return o;
    endfunction

    // Reference: remaining squash slots counted down on unstalled edges.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (cur.rst) begin
                m_out[i]  = bubble(32'h0);
                m_left[i] = 0;
                m_sc[i]   = 32'h0;
                m_fc[i]   = 32'h0;
            end else if (cur.fl) begin
                m_out[i]  = bubble(cur.pc);
                m_left[i] = fc_of[i] - 1;
                m_fc[i]   = m_fc[i] + 32'd1;
            end else if (cur.stl) begin
                m_sc[i] = m_sc[i] + 32'd1;
            end else if (m_left[i] > 0) begin
                m_out[i]  = bubble(cur.pc);
                m_left[i] = m_left[i] - 1;
            end else begin
                m_out[i].op  = cur.op;
                m_out[i].fn  = cur.fn;
                m_out[i].pc  = cur.pc;
                m_out[i].rs1 = cur.rs1;
                m_out[i].rs2 = cur.rs2;
                m_out[i].rd  = {cur.fp, cur.rd};
                m_out[i].imm = cur.imm;
                m_out[i].v   = !(cur.op == 6'h00 && cur.fn == c_NOPF);
            end
        end
    endtask

    task automatic check_model();
        chk("fc2_outputs", 96'(g0), 96'(m_out[0]));
        chk("fc3_outputs", 96'(g1), 96'(m_out[1]));
`ifdef FD_PERF_CNT_EN
        chk("fc2_stallcnt", 96'(sc0), 96'(m_sc[0]));
        chk("fc2_flushcnt", 96'(fc0), 96'(m_fc[0]));
        chk("fc3_stallcnt", 96'(sc1), 96'(m_sc[1]));
        chk("fc3_flushcnt", 96'(fc1), 96'(m_fc[1]));
`else
        chk("stallcnt_zero", 96'({sc0, sc1}), 96'h0);
        chk("flushcnt_zero", 96'({fc0, fc1}), 96'h0);
`endif
    endtask

    task automatic step(input ins_t x);
        cur        = x;
        reset      = x.rst;
        stall      = x.stl;
        flush      = x.fl;
        OpCode     = x.op;
        Function   = x.fn;
        Rs1        = x.rs1;
        Rs2        = x.rs2;
        Rd         = x.rd;
        RdIsFp     = x.fp;
        Immediate  = x.imm;
        PCPlusFour = x.pc;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    function automatic ins_t mki(input logic r, input logic s, input logic f,
                                 input logic [5:0] op, input logic [5:0] fn,
                                 input logic [4:0] rd, input logic fp,
                                 input logic [31:0] pc);
        ins_t x;
        x.rst = r;  x.stl = s;  x.fl = f;
        x.op  = op; x.fn  = fn; x.rd = rd; x.fp = fp; x.pc = pc;
        x.rs1 = pc[6:2] + 5'd2;
        x.rs2 = ~pc[6:2];
        x.imm = pc[15:0] ^ 16'h0114;
        return x;
    endfunction

    function automatic vec_t mk(input logic r, input logic s, input logic f,
                                input logic [5:0] op, input logic [5:0] fn,
                                input logic [4:0] rd, input logic fp,
                                input logic [31:0] pc, input logic [5:0] eop,
                                input logic [5:0] erd, input logic [31:0] epc,
                                input logic ev);
        vec_t t;
        t.in   = mki(r, s, f, op, fn, rd, fp, pc);
        t.e_op = eop; t.e_rd = erd; t.e_pc = epc; t.e_v = ev;
        return t;
    endfunction

    vec_t tbl[22];

    initial begin
        int bubbles;
        bit done;
        ins_t x;

        fc_of[0] = 2;
        fc_of[1] = 3;
        for (int i = 0; i < 2; i++) begin
            m_out[i] = bubble(32'h0); m_left[i] = 0; m_sc[i] = '0; m_fc[i] = '0;
        end

        // Expectations below are for the FlushCycles=2 instance.
        tbl[0]  = mk(1,1,1, 6'h23,6'h20, 5'd5,1, 32'h050, 6'h00,6'h00,32'h000,0);
        tbl[1]  = mk(1,1,1, 6'h23,6'h20, 5'd5,1, 32'h050, 6'h00,6'h00,32'h000,0);
        tbl[2]  = mk(0,0,0, 6'h23,6'h20, 5'd5,1, 32'h104, 6'h23,6'h25,32'h104,1);
        tbl[3]  = mk(0,1,0, 6'h0a,6'h20, 5'd7,0, 32'h108, 6'h23,6'h25,32'h104,1);
        tbl[4]  = mk(0,1,0, 6'h0b,6'h20, 5'd7,0, 32'h10c, 6'h23,6'h25,32'h104,1);
        tbl[5]  = mk(0,1,0, 6'h0c,6'h20, 5'd7,0, 32'h110, 6'h23,6'h25,32'h104,1);
        tbl[6]  = mk(0,0,0, 6'h0d,6'h20, 5'd9,0, 32'h114, 6'h0d,6'h09,32'h114,1);
        tbl[7]  = mk(0,0,1, 6'h0e,6'h20, 5'd4,0, 32'h118, 6'h00,6'h00,32'h118,0);
        tbl[8]  = mk(0,0,0, 6'h0f,6'h20, 5'd6,0, 32'h11c, 6'h00,6'h00,32'h11c,0);
        tbl[9]  = mk(0,0,0, 6'h10,6'h20, 5'd8,0, 32'h120, 6'h10,6'h08,32'h120,1);
        tbl[10] = mk(0,0,0, 6'h00,c_NOPF,5'd3,0, 32'h124, 6'h00,6'h03,32'h124,0);
        tbl[11] = mk(0,1,1, 6'h11,6'h20, 5'd2,0, 32'h128, 6'h00,6'h00,32'h128,0);
        tbl[12] = mk(0,1,0, 6'h12,6'h20, 5'd2,0, 32'h12c, 6'h00,6'h00,32'h128,0);
        tbl[13] = mk(0,0,0, 6'h13,6'h20, 5'd2,0, 32'h130, 6'h00,6'h00,32'h130,0);
        tbl[14] = mk(0,0,0, 6'h14,6'h20, 5'd1,0, 32'h134, 6'h14,6'h01,32'h134,1);
        tbl[15] = mk(0,0,1, 6'h15,6'h20, 5'd1,0, 32'h138, 6'h00,6'h00,32'h138,0);
        tbl[16] = mk(0,0,1, 6'h16,6'h20, 5'd1,0, 32'h13c, 6'h00,6'h00,32'h13c,0);
        tbl[17] = mk(0,0,0, 6'h17,6'h20, 5'd31,0,32'h140, 6'h00,6'h00,32'h140,0);
        tbl[18] = mk(0,0,0, 6'h18,6'h20, 5'd31,1,32'h144, 6'h18,6'h3f,32'h144,1);
        tbl[19] = mk(0,0,1, 6'h19,6'h20, 5'd1,0, 32'h148, 6'h00,6'h00,32'h148,0);
        tbl[20] = mk(1,0,0, 6'h1a,6'h20, 5'd1,0, 32'h14c, 6'h00,6'h00,32'h000,0);
        tbl[21] = mk(0,0,0, 6'h1b,6'h20, 5'd2,0, 32'h150, 6'h1b,6'h02,32'h150,1);

        for (int i = 0; i < 22; i++) begin
            step(tbl[i].in);
            chk($sformatf("tbl%0d_op", i), 96'(g0.op), 96'(tbl[i].e_op));
            chk($sformatf("tbl%0d_rd", i), 96'(g0.rd), 96'(tbl[i].e_rd));
            chk($sformatf("tbl%0d_pc", i), 96'(g0.pc), 96'(tbl[i].e_pc));
            chk($sformatf("tbl%0d_valid", i), 96'(g0.v), 96'(tbl[i].e_v));
            if (i == 1) begin
                chk("reset_dfunction", 96'(g0.fn), 96'(c_NOPF));
            end
        end

        // FlushCycles=3: flush+stall, stall through squash, count bubble slots.
        step(mki(0,1,1, 6'h2a,6'h01, 5'd3,0, 32'h200));
        bubbles = (g1.v == 1'b0) ? 1 : 0;
        step(mki(0,1,0, 6'h2a,6'h01, 5'd3,0, 32'h204));
        step(mki(0,1,0, 6'h2a,6'h01, 5'd3,0, 32'h208));
        chk("fc3_hold_pc", 96'(g1.pc), 96'h200);
        done = 1'b0;
        for (int k = 0; k < 8 && !done; k++) begin
            step(mki(0,0,0, 6'h2a,6'h01, 5'd3,0, 32'h20c + 32'(4*k)));
            if (g1.v) done = 1'b1;
            else      bubbles++;
        end
        chk("fc3_reached_run", 96'(done), 96'h1);
        chk("fc3_bubble_slots", 96'(bubbles), 96'd3);

`ifdef FD_PERF_CNT_EN
        @(negedge clk);
        force dut2.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut2.stall_cnt_q;
        m_sc[0] = 32'hFFFF_FFFF;
        step(mki(0,1,0, 6'h2b,6'h01, 5'd3,0, 32'h300));
        chk("stallcnt_wrap", 96'(sc0), 96'h0);
`endif

        for (int n = 0; n < 400; n++) begin
            x     = mki($urandom_range(0,49) == 0, $urandom_range(0,3) == 0,
                        $urandom_range(0,9) == 0, 6'($urandom), 6'($urandom),
                        5'($urandom), 1'($urandom), $urandom);
            x.rs1 = 5'($urandom);
            x.imm = 16'($urandom);
            if ($urandom_range(0,6) == 0) begin
                x.op = 6'h00;
                x.fn = c_NOPF;
            end
            step(x);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
